ps2_key_encoder: RTL and testbench

//  Deserialises a raw PS/2 keyboard stream (open-drain clk/data, device-driven) and produces the
//  11-bit toggle-handshake key event word consumed by the core's keyboard decoders:
//  {toggle, pressed, extended, code[7:0]}. Sits between the user/PS2 pins and the emu-level

---
 rtl/ps2_key_encoder_if.sv | 11 +
 rtl/ps2_key_encoder.sv | 148 ++++++++++++++
 tb/tb_ps2_key_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_encoder_if.sv
// Key event bus from the PS/2 receiver: the toggle-handshake key word
// plus its one-cycle strobe and the frame error pulse.
`timescale 1ns/1ps
interface ps2_key_encoder_if;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;

    modport master (output ps2_key, output key_strobe, output frame_err);
    modport slave  (input  ps2_key, input  key_strobe, input  frame_err);
endinterface

// File: rtl/ps2_key_encoder.sv
// Receive-only PS/2 keyboard deserialiser producing the 11-bit toggle-handshake
// key event word {toggle, pressed, extended, code}.
`timescale 1ns/1ps
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 48000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    ps2_key_encoder_if.master key_if
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           clk_filt;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    state_t         state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           parity_bit;
    logic [TCW-1:0] idle_cnt;
    logic           ext, rel;
    logic [2:0]     skip_cnt;
    logic [10:0]    key_q;
    logic           strobe_q, err_q;
    logic           frame_ok;

    // NOTE: every clocked block uses non-blocking (<=) so all flops update from
    // pre-edge values; blocking here would turn the synchroniser into a wire.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Reset to the idle-high bus level so no phantom edge appears on release.
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    // Any sample matching the accepted level restarts the run, so only a
    // steady run of FILTER_LEN differing samples flips clk_filt.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign fall     = clk_filt && !clk_s2 && (filt_cnt == FCW'(FILTER_LEN - 1));
    assign frame_ok = data_s2 && ((^shift_reg) ^ parity_bit);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            idle_cnt   <= '0;
            ext        <= 1'b0;
            rel        <= 1'b0;
            skip_cnt   <= '0;
            key_q      <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= data_s2;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            err_q <= 1'b1;
                            ext   <= 1'b0;
                            rel   <= 1'b0;
                        end else if (skip_cnt != 3'd0) begin
                            skip_cnt <= skip_cnt - 1'b1;
                        end else if (shift_reg == 8'hE1) begin
                            skip_cnt <= 3'd7;
                        end else if (shift_reg == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            rel <= 1'b1;
                        end else begin
                            key_q    <= {~key_q[10], ~rel, ext, shift_reg};
                            strobe_q <= 1'b1;
                            ext      <= 1'b0;
                            rel      <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                if (idle_cnt != TCW'(TIMEOUT - 1))
                    idle_cnt <= idle_cnt + 1'b1;
                // A stalled partial frame is abandoned; IDLE itself never times out.
                if (state != IDLE && idle_cnt == TCW'(TIMEOUT - 1)) begin
                    state <= IDLE;
                    err_q <= 1'b1;
                    ext   <= 1'b0;
                    rel   <= 1'b0;
                end
            end
        end
    end

    assign key_if.ps2_key    = key_q;
    assign key_if.key_strobe = strobe_q;
    assign key_if.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: directed PS/2 frames push expected
// events; an independent monitor pops and compares on each strobe/error pulse.
`timescale 1ns/1ps
module tb_ps2_key_encoder;

    localparam int HALF = 50;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_err;
        logic [10:0] value;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ps2_key_encoder_if key_if ();

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(48000)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk_in (ps2_clk),
        .ps2_data_in(ps2_data),
        .key_if     (key_if)
    );

    always #1 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [10:0] actual, input logic [10:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_key(input logic [10:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.value  = v;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [10:0] hold);
        exp_t e;
        e.is_err = 1'b1;
        e.value  = hold;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_sys) begin
        if (!reset && (key_if.key_strobe || key_if.frame_err)) begin
            check("strobe_err_exclusive", {10'd0, key_if.key_strobe & key_if.frame_err}, 11'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {9'd0, key_if.key_strobe, key_if.frame_err}, 11'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {10'd0, key_if.frame_err}, {10'd0, mon_e.is_err});
                check("ps2_key", key_if.ps2_key, mon_e.value);
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk_sys);
        ps2_data = b;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check("reset_ps2_key", key_if.ps2_key, 11'h000);
        check("reset_strobe", {10'd0, key_if.key_strobe}, 11'd0);
        check("reset_frame_err", {10'd0, key_if.frame_err}, 11'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (2 * HALF) @(negedge clk_sys);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, 11'(exp_q.size()), 11'd0);
    endtask

    initial begin
        repeat (4) @(negedge clk_sys);
        do_reset();

        // 1: plain make code
        push_key(11'h629);
        send_frame(8'h29);
        wait_drain("t1_make");

        // 2: break code, single event after the F0 prefix
        push_key(11'h029);
        send_frame(8'hF0);
        send_frame(8'h29);
        wait_drain("t2_break");

        // 3: extended make then extended break
        push_key(11'h775);
        send_frame(8'hE0);
        send_frame(8'h75);
        push_key(11'h175);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        wait_drain("t3_extended");

        // 4: parity error keeps the key word, next good frame decodes
        push_err(11'h175);
        send_frame(8'h1C, 1'b1);
        push_key(11'h61C);
        send_frame(8'h1C);
        wait_drain("t4_parity");

        // 5: stalled partial frame times out
        do_reset();
        push_err(11'h000);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (48500) @(negedge clk_sys);
        wait_drain("t5_timeout");
        push_key(11'h616);
        send_frame(8'h16);
        wait_drain("t5_after_timeout");

        // 6: Pause sequence is swallowed whole
        do_reset();
        send_frame(8'hE1);
        send_frame(8'h14);
        send_frame(8'h77);
        send_frame(8'hE1);
        send_frame(8'hF0);
        send_frame(8'h14);
        send_frame(8'hF0);
        send_frame(8'h77);
        push_key(11'h605);
        send_frame(8'h05);
        wait_drain("t6_pause");

        // 7: reset in the middle of a frame discards it
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        ps2_data = 1'b1;
        do_reset();
        push_key(11'h629);
        send_frame(8'h29);
        wait_drain("t7_after_reset");

        repeat (20) @(negedge clk_sys);
        check("final_queue_empty", 11'(exp_q.size()), 11'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
